// File: rtl/idli_pkg.sv
// Shared types for the idli core: pad direction and SQI controller state.
package idli_pkg;

  typedef enum logic {
    SQI_MODE_IN  = 1'b0,
    SQI_MODE_OUT = 1'b1
  } sqi_mode_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_END   = 3'd5
  } sqi_state_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

endpackage

// File: rtl/idli_sqi_ctrl.sv
// Quad-SPI master for the external code/data SRAM: opcode + 16-bit address,
// then nibble streaming until a stop request lands on a byte boundary.
module idli_sqi_ctrl
  import idli_pkg::*;
#(
  parameter logic [7:0]  CMD_READ     = SQI_CMD_READ,
  parameter logic [7:0]  CMD_WRITE    = SQI_CMD_WRITE,
  parameter int unsigned DUMMY_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [15:0] i_addr,
  input  logic        i_stop,
  input  logic [3:0]  i_wdata,
  input  logic        i_wdata_vld,
  output logic        o_wdata_rdy,
  output logic [3:0]  o_rdata,
  output logic        o_rdata_vld,
  output logic        o_busy,
  output logic        o_sqi_cs_n,
  output logic        o_sqi_sck_en,
  output sqi_mode_t   o_sqi_mode,
  output logic [3:0]  o_sqi_sio,
  input  logic [3:0]  i_sqi_sio
);

  localparam logic [2:0] CMD_LAST   = 3'd1;
  localparam logic [2:0] ADDR_LAST  = 3'd3;
  localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);

  sqi_state_t  state;
  sqi_state_t  state_nxt;
  logic [23:0] hdr_sreg;
  logic [2:0]  phase;
  logic        wr_txn;
  logic        parity;
  logic        stop_seen;
  logic        xfer;

  // Pad controls are decoded from the state so CS and direction follow the FSM exactly.
  always_comb begin
    state_nxt    = state;
    o_sqi_cs_n   = 1'b1;
    o_sqi_sck_en = 1'b0;
    o_sqi_mode   = SQI_MODE_IN;
    o_sqi_sio    = 4'h0;
    o_wdata_rdy  = 1'b0;
    xfer         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req) state_nxt = ST_CMD;
      end
      ST_CMD: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_mode   = SQI_MODE_OUT;
        o_sqi_sio    = hdr_sreg[23:20];
        if (phase == CMD_LAST) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_mode   = SQI_MODE_OUT;
        o_sqi_sio    = hdr_sreg[23:20];
        if (phase == ADDR_LAST) state_nxt = wr_txn ? ST_DATA : ST_DUMMY;
      end
      ST_DUMMY: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        if (phase == DUMMY_LAST) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        o_sqi_cs_n = 1'b0;
        if (wr_txn) begin
          o_sqi_mode   = SQI_MODE_OUT;
          o_sqi_sio    = i_wdata;
          o_wdata_rdy  = i_wdata_vld;
          o_sqi_sck_en = i_wdata_vld;
          xfer         = i_wdata_vld;
        end else begin
          o_sqi_sck_en = 1'b1;
          xfer         = 1'b1;
        end
        // parity=1 means this nibble closes a byte, the only legal exit point
        if (xfer && parity && (stop_seen || i_stop)) state_nxt = ST_END;
      end
      ST_END: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_busy = (state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      phase       <= 3'd0;
      hdr_sreg    <= 24'h0;
      wr_txn      <= 1'b0;
      parity      <= 1'b0;
      stop_seen   <= 1'b0;
      o_rdata     <= 4'h0;
      o_rdata_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= (state_nxt != state) ? 3'd0 : phase + 3'd1;

      if (state == ST_IDLE) begin
        parity    <= 1'b0;
        stop_seen <= 1'b0;
        if (i_req) begin
          wr_txn   <= i_wr;
          hdr_sreg <= {(i_wr ? CMD_WRITE : CMD_READ), i_addr};
        end
      end else begin
        if (i_stop) stop_seen <= 1'b1;
        if (state == ST_CMD || state == ST_ADDR) hdr_sreg <= {hdr_sreg[19:0], 4'h0};
        if (xfer) parity <= ~parity;
      end

      o_rdata_vld <= (state == ST_DATA) && !wr_txn;
      if ((state == ST_DATA) && !wr_txn) o_rdata <= i_sqi_sio;
    end
  end

endmodule
